// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready handshake.
// An optional second (skid) entry keeps in_ready registered, a synchronous
// NOP_CLR flushes the stage into a bubble, and two saturating counters
// record stall and bubble cycles.
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              NOP_CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                accept;
  logic                pop;

  // Main entry is zeroed whenever the stage is empty, so the outputs read
  // straight from registers and a bubble is all-zero without extra gating.
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = state_q;

  // With a skid entry in_ready is a pure state decode; without it the
  // stage must look at out_ready to allow back-to-back transfers.
  assign in_ready = (SKID != 0) ? (state_q != ST_SKID)
                                : (~out_valid | out_ready);

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  // Next-state and entry update; NOP_CLR overrides any handshake.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (NOP_CLR) begin
      state_d     = ST_EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_FULL;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ST_FULL: begin
          if (accept && pop) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (pop) begin
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_ctrl_d = '0;
          end else if (accept && (SKID != 0)) begin
            state_d     = ST_SKID;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end
        end
        ST_SKID: begin
          if (pop) begin
            state_d     = ST_FULL;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_data_d = '0;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_data_d = '0;
          main_ctrl_d = '0;
          skid_data_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  // State and entry registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Saturating performance counters from pre-edge outputs; NOP_CLR does not clear them.
  always_ff @(posedge CLK) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (!out_valid && (bubble_cnt != CNT_MAX))
        bubble_cnt <= bubble_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register. It is the generalised successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload bus and a control bus of configurable width.
- Uses a valid/ready handshake instead of a free-running latch, so back-pressure from a downstream stall never drops an instruction.
- Has an optional 2-entry skid buffer, a synchronous NOP_CLR bubble insert, and saturating stall/bubble performance counters.

Parameters:
DATA_W, 160, payload width (e.g. IR, V1, V2, extended immediates, PC+4 concatenated).
CTRL_W, 16, control-bit width (RegWrite, MemWrite, ALUControl, ...).
SKID, 1, 1 = two entries (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
CNT_W, 16, width of each performance counter.

Ports:
CLK  in  1  clock, all state updates on rising edge.
reset  in  1  synchronous, active-high; clears all state including counters.
NOP_CLR  in  1  synchronous flush; empties stage, inserts bubble.
in_valid  in  1  upstream has an instruction.
in_ready  out  1  stage can accept this cycle.
in_data  in  DATA_W  upstream payload.
in_ctrl  in  CTRL_W  upstream control bits.
out_valid  out  1  out_data/out_ctrl hold a live instruction.
out_ready  in  1  downstream consumes this cycle.
out_data  out  DATA_W  payload of head entry; all-zero when out_valid=0.
out_ctrl  out  CTRL_W  control of head entry; all-zero when out_valid=0.
occupancy  out  2  entries held: 0, 1, or 2 (2 only when SKID=1).
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
bubble_cnt  out  CNT_W  cycles with out_valid=0.

Behaviour:
- Transfers: accept = in_valid & in_ready; pop = out_valid & out_ready.
- Reset: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, skid entry zeroed, stall_cnt=0, bubble_cnt=0. in_ready=1 in the cycle after reset.
- Priority: reset > NOP_CLR > handshake.
- Latency: an accepted word appears on out_* on the next edge (1 cycle). The output is fully registered, with no in→out combinational path.
- SKID=1 states (occupancy encodes them):
  - EMPTY (0), in_ready=1:
    - accept → FULL; main<=in.
  - FULL (1), in_ready=1:
    - accept & pop → FULL; main<=in.
    - pop & ~accept → EMPTY; main cleared to 0.
    - accept & ~pop → SKID; skid<=in.
    - otherwise hold.
  - SKID (2), in_ready=0:
    - pop → FULL; main<=skid, skid cleared to 0.
    - otherwise hold; no input is accepted.
  - in_ready is a registered signal: in_ready = (state != SKID).
- SKID=0 (single entry):
  - in_ready = ~out_valid | out_ready (combinational).
  - accept → main<=in, out_valid=1.
  - pop & ~accept → EMPTY; main cleared to 0.
  - occupancy never exceeds 1.
- NOP_CLR (when reset=0):
  - Next edge: both entries cleared to zero and out_valid=0 (state EMPTY).
  - Any word accepted or popped in that cycle is discarded; the handshake is not aborted combinationally.
  - Counters are not cleared by NOP_CLR.
  - in_ready=1 in the following cycle.
- Counters:
  - Evaluated from pre-edge outputs each non-reset cycle, including NOP_CLR cycles.
  - stall_cnt += (out_valid & ~out_ready).
  - bubble_cnt += ~out_valid.
  - Both saturate at 2^CNT_W−1; no wrap.
- Invariants:
  - out_valid=0 ⇒ out_data=0 and out_ctrl=0, so a bubble decodes as a NOP with all write enables low.
  - No word is duplicated or lost except under NOP_CLR or reset.
  - Order is preserved: FIFO, skid drains before new input.
- Reset or NOP_CLR asserted while in SKID: both entries are dropped in one edge.

Test Plan:
- Streaming: reset 2 cycles, then in_valid=1 with in_data=1,2,3,... and out_ready=1 for 10 cycles → out_data=1..10, one cycle behind; occupancy=1; stall_cnt=0.
- Back-pressure (SKID=1): stream 0xA,0xB,0xC and drop out_ready after 0xA appears → 0xB captured in skid, occupancy=2, in_ready=0 next cycle, 0xC held upstream. Raise out_ready → output sequence 0xA,0xB,0xC, no loss or duplicate; stall_cnt equals the stall cycles.
- Flush in SKID: occupancy=2 with in_valid=1, assert NOP_CLR for 1 cycle → next cycle out_valid=0, out_data=0, out_ctrl=0, occupancy=0, in_ready=1; counters keep their values.
- Priority: assert reset and NOP_CLR together with in_valid=1 → all outputs 0 and stall_cnt=bubble_cnt=0. NOP_CLR alone → counters unchanged.
- SKID=0 build: out_ready=0 with in_valid=1 → in_ready=0 while out_valid=1. Set out_ready=1 and in_valid=1 in the same cycle → in_ready=1 combinationally, back-to-back transfer, occupancy stays 1.
- Saturation: CNT_W=4, keep out_valid=0 for 20 cycles after reset → bubble_cnt climbs to 15 and stays at 15.
